mem_port_arbiter: RTL and testbench

Arbitrates the CPU's instruction-fetch port and data (load/store) port onto one shared SRAM-like memory port with req/addr_ok/data_ok handshakes. Sits between the pipeline's fetch and MEM-stage interfaces and the single memory bridge. It tracks one outstanding transaction, routes `data_ok`/`rdata` back to the requester that owns it, and flags protocol violations. Store byte-enable generation stays in the MEM stage; this block passes `wstrb` through unchanged.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one SRAM-like memory port between instruction fetch and
//             data access, with one outstanding transaction and a sticky
//             protocol-error flag. Define ARB_RR_EN for round-robin arbitration.
//  Revision : 1.0
// ============================================================================
module mem_port_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] C_INST_SIZE = 2'b10;

  state_t r_state;
  state_t w_next;
  logic   r_own;
  logic   r_perr;
  logic   w_any;
  logic   w_gnt;
  logic   w_sel;
  logic   w_req;

  assign w_any = inst_req | data_req;

`ifdef ARB_RR_EN
  logic r_ptr;
  // Pointer only matters on a conflict; a lone requester always wins.
  assign w_gnt = (inst_req && data_req) ? r_ptr : data_req;
`else
  assign w_gnt = data_req;
`endif

  assign w_sel = (r_state == IDLE) ? w_gnt : r_own;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_own  <= 1'b0;
      r_perr <= 1'b0;
`ifdef ARB_RR_EN
      r_ptr  <= 1'b1;
`endif
    end else begin
      if (r_state == IDLE && w_any) begin
        r_own <= w_gnt;
      end
      // Any return outside DATA, including on the grant edge, is spurious.
      if (mem_data_ok && r_state != DATA) begin
        r_perr <= 1'b1;
      end
`ifdef ARB_RR_EN
      if (w_req && mem_addr_ok) begin
        r_ptr <= ~w_sel;
      end
`endif
    end
  end

  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req  = 1'b1;
          w_next = mem_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        w_req = 1'b1;
        if (mem_addr_ok) begin
          w_next = DATA;
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          inst_data_ok = ~r_own;
          data_data_ok = r_own;
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Handshake strobes are held low for the whole reset assertion.
    if (!resetn) begin
      w_req        = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

  assign mem_req      = w_req;
  assign inst_addr_ok = w_req & ~w_sel & mem_addr_ok;
  assign data_addr_ok = w_req & w_sel & mem_addr_ok;

  assign mem_wr    = w_sel & data_wr;
  assign mem_size  = w_sel ? data_size  : C_INST_SIZE;
  assign mem_addr  = w_sel ? data_addr  : inst_addr;
  assign mem_wstrb = w_sel ? data_wstrb : 4'b0000;
  assign mem_wdata = w_sel ? data_wdata : 32'h0000_0000;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign busy       = (r_state != IDLE);
  assign proto_err  = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed and random stimulus for mem_port_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr, busy, proto_err;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;

  int n_vec = 0;
  int n_err = 0;

  // Model: a transaction is in flight, and whether its address was accepted.
  bit m_busy, m_acc, m_own, m_ptr, m_perr;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_rst(input bit v);
    resetn = v;
    if (!v) begin
      m_busy = 0; m_acc = 0; m_own = 0; m_ptr = 1; m_perr = 0;
    end
  endtask

  function automatic bit pick();
    if (m_busy) return m_own;
    if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      return m_ptr;
`else
      return 1'b1;
`endif
    end
    return data_req;
  endfunction

  // Check all outputs for the current inputs, then advance one clock.
  task automatic step();
    bit o, eq, ed;
    #2;
    o  = pick();
    eq = resetn && (m_busy ? !m_acc : (inst_req || data_req));
    ed = resetn && m_busy && m_acc && mem_data_ok;
    chk("mem_req",      32'(mem_req),      32'(eq));
    chk("mem_wr",       32'(mem_wr),       32'(o & data_wr));
    chk("mem_size",     32'(mem_size),     32'(o ? data_size : 2'b10));
    chk("mem_addr",     mem_addr,          o ? data_addr : inst_addr);
    chk("mem_wstrb",    32'(mem_wstrb),    32'(o ? data_wstrb : 4'b0000));
    chk("mem_wdata",    mem_wdata,         o ? data_wdata : 32'h0);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(eq & !o & mem_addr_ok));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(eq & o & mem_addr_ok));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(ed & !m_own));
    chk("data_data_ok", 32'(data_data_ok), 32'(ed & m_own));
    chk("inst_rdata",   inst_rdata,        mem_rdata);
    chk("data_rdata",   data_rdata,        mem_rdata);
    chk("busy",         32'(busy),         32'(m_busy));
    chk("proto_err",    32'(proto_err),    32'(m_perr));
    @(posedge clk);
    if (resetn) begin
      if (mem_data_ok && !(m_busy && m_acc)) m_perr = 1;
      if (eq && mem_addr_ok) m_ptr = !o;
      if (!m_busy) begin
        if (inst_req || data_req) begin
          m_busy = 1; m_own = o; m_acc = mem_addr_ok;
        end
      end else if (!m_acc) begin
        m_acc = mem_addr_ok;
      end else if (mem_data_ok) begin
        m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 2'b10;
    inst_addr = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    set_rst(0);
    step();
    step();
    set_rst(1);
    step();

    // Lone fetch with immediate address acceptance.
    inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h2408_0001;
    #1;
    chk("fetch_data_ok", 32'(inst_data_ok), 32'd1);
    chk("fetch_rdata", inst_rdata, 32'h2408_0001);
    step();
    mem_data_ok = 0;
    step();

    // Lone store stalled on address acceptance; a fetch arrives meanwhile.
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
    data_wstrb = 4'b1000; data_wdata = 32'hAAAA_AAAA;
    step();
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    for (int i = 0; i < 2; i++) step();
    #1;
    chk("store_busy", 32'(busy), 32'd1);
    chk("store_addr", mem_addr, 32'h8000_0010);
    mem_addr_ok = 1;
    step();
    data_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 2; i++) step();
    mem_data_ok = 1;
    step();
    mem_data_ok = 0; inst_req = 0;
    step();

    // Spurious return while idle, then reset clears the flag.
    mem_data_ok = 1;
    step();
    mem_data_ok = 0;
    step();
    chk("perr_sticky", 32'(proto_err), 32'd1);
    set_rst(0);
    step();
    set_rst(1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 6);
      data_wr     = 1'($urandom);
      data_size   = 2'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      data_wstrb  = 4'($urandom);
      data_wdata  = $urandom;
      mem_rdata   = $urandom;
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (m_busy && m_acc) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
      set_rst($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
